// File: rtl/modem_rx_deframer_if.sv
// Receive byte hand-off between the deframer and its consumer.
//   rx_data  : recovered byte (master -> slave)
//   rx_valid : holding register full (master -> slave)
//   rx_ready : consumer takes rx_data this cycle (slave -> master)
interface modem_rx_deframer_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/modem_rx_deframer.sv
// Oversampling start/stop deframer for the demodulated bit stream.
// Majority-votes three synchronized samples per bit and hands recovered
// bytes to a single-entry valid/ready holding register.
//   clk, rst_n : clock, async active-low reset
//   ena        : enable; low returns the FSM to IDLE
//   demod_in   : demodulated serial stream, idle high
//   err_clr    : clears sticky overrun
//   rx         : byte hand-off (rx_data / rx_valid / rx_ready)
//   frame_err  : one-cycle pulse on a low stop bit
//   overrun    : sticky, good frame dropped because the register was full
//   busy       : FSM not in IDLE
module modem_rx_deframer #(
  parameter int unsigned OSR       = 16,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       demod_in,
  input  logic                       err_clr,
  modem_rx_deframer_if.master        rx,
  output logic                       frame_err,
  output logic                       overrun,
  output logic                       busy
);

  localparam int unsigned BCW = $clog2(OSR);
  localparam int unsigned IW  = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           sync_q;
  logic [2:0]           hist_q;
  logic [BCW-1:0]       bcnt_q, bcnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q, busy_d;

  logic maj_c, fall_c, line_c, half_c, bit_end_c, good_c, load_c;

  // hist_q[0] is the synchronized line; older samples feed the vote
  assign line_c    = hist_q[0];
  assign fall_c    = hist_q[1] & ~hist_q[0];
  assign maj_c     = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) |
                     (hist_q[1] & hist_q[2]);
  assign half_c    = (bcnt_q == BCW'(OSR/2 - 1));
  assign bit_end_c = (bcnt_q == BCW'(OSR - 1));

  // Next-state, datapath and holding-register logic
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q + 1'b1;
    idx_d   = idx_q;
    sr_d    = sr_q;
    good_c  = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        bcnt_d = '0;
        idx_d  = '0;
        if (fall_c) state_d = S_START;
      end
      S_START: begin
        if (half_c) begin
          bcnt_d  = '0;
          state_d = maj_c ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end_c) begin
          bcnt_d = '0;
          sr_d   = {maj_c, sr_q[DATA_BITS-1:1]};
          if (idx_q == IW'(DATA_BITS - 1)) state_d = S_STOP;
          else                             idx_d   = idx_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end_c) begin
          bcnt_d = '0;
          if (maj_c) begin
            good_c  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        bcnt_d = '0;
        if (line_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Disable drops any partial frame but leaves the holding register alone
    if (!ena) begin
      state_d = S_IDLE;
      bcnt_d  = '0;
      good_c  = 1'b0;
      ferr_d  = 1'b0;
    end

    // A full register accepts a new byte only if it is drained the same cycle
    load_c  = good_c & (~valid_q | rx.rx_ready);
    data_d  = load_c ? sr_q : data_q;
    valid_d = valid_q;
    if (load_c)                     valid_d = 1'b1;
    else if (valid_q && rx.rx_ready) valid_d = 1'b0;

    ovr_d = ovr_q;
    if (good_c && valid_q && !rx.rx_ready) ovr_d = 1'b1;
    else if (err_clr)                      ovr_d = 1'b0;

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      hist_q  <= 3'b111;
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      idx_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], demod_in};
      hist_q  <= {hist_q[1:0], sync_q[1]};
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign rx.rx_data  = data_q;
  assign rx.rx_valid = valid_q;
  assign frame_err   = ferr_q;
  assign overrun     = ovr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_modem_rx_deframer.sv
// Directed bench for modem_rx_deframer (OSR=16, 8 data bits).
module tb_modem_rx_deframer;

  logic clk      = 1'b0;
  logic rst_n    = 1'b1;
  logic ena      = 1'b1;
  logic demod_in = 1'b1;
  logic err_clr  = 1'b0;
  logic frame_err, overrun, busy;

  int checks = 0;
  int errors = 0;

  modem_rx_deframer_if #(.DATA_BITS(8)) dif ();

  modem_rx_deframer #(.OSR(16), .DATA_BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .demod_in  (demod_in),
    .err_clr   (err_clr),
    .rx        (dif),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Edge counter plus event log, sampled 1 ns after each rising edge
  int         cyc       = 0;
  int         vrise_n   = 0;
  int         vrise_cyc = -1;
  int         vhigh_n   = 0;
  int         ferr_n    = 0;
  int         ferr_cyc  = -1;
  logic [7:0] vrise_data = 8'h00;
  logic       vprev     = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (dif.rx_valid === 1'b1 && vprev == 1'b0) begin
      vrise_n    = vrise_n + 1;
      vrise_cyc  = cyc;
      vrise_data = dif.rx_data;
    end
    if (dif.rx_valid === 1'b1) vhigh_n = vhigh_n + 1;
    if (frame_err === 1'b1) begin
      ferr_n   = ferr_n + 1;
      ferr_cyc = cyc;
    end
    vprev = (dif.rx_valid === 1'b1);
  end

  // Line level at offset i of a frame: start, 8 data bits LSB first, stop
  function automatic logic frame_bit(input logic [7:0] d, input logic stop, input int i);
    int k;
    k = i / 16;
    if (k == 0)      return 1'b0;
    else if (k <= 8) return d[3'(k - 1)];
    else             return stop;
  endfunction

  // Drives 160 line cycles; c is the first rising edge that sees the start bit.
  // The line is left at the stop level so frames can follow back-to-back.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int gpos, output int c);
    @(negedge clk);
    c = cyc + 1;
    for (int i = 0; i < 160; i++) begin
      if (i > 0) @(negedge clk);
      demod_in = frame_bit(d, stop, i) ^ (i == gpos);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (dif.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", dif.rx_valid); end
    checks++; if (dif.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", dif.rx_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic;
    int c, r0, h0, f0;
    dif.rx_ready = 1'b1;
    r0 = vrise_n; h0 = vhigh_n; f0 = ferr_n;
    send_frame(8'hA5, 1'b1, -1, c);
    wait_until(c + 170);
    checks++; if (vrise_n - r0 !== 1) begin errors++; $display("FAIL basic_count got %0d want 1", vrise_n - r0); end
    checks++; if (vrise_cyc !== c + 155) begin errors++; $display("FAIL basic_latency got %0d want %0d", vrise_cyc - c, 155); end
    checks++; if (vhigh_n - h0 !== 1) begin errors++; $display("FAIL basic_valid_width got %0d want 1", vhigh_n - h0); end
    checks++; if (vrise_data !== 8'hA5) begin errors++; $display("FAIL basic_data got %h want a5", vrise_data); end
    checks++; if (ferr_n - f0 !== 0) begin errors++; $display("FAIL basic_ferr got %0d want 0", ferr_n - f0); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL basic_overrun got %b want 0", overrun); end
  endtask

  task automatic test_short_pulse;
    int c, r0, f0;
    r0 = vrise_n; f0 = ferr_n;
    @(negedge clk);
    c = cyc + 1;
    demod_in = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pulse_busy_high got %b want 1", busy); end
    demod_in = 1'b1;
    wait_until(c + 30);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pulse_busy_low got %b want 0", busy); end
    checks++; if (vrise_n - r0 !== 0) begin errors++; $display("FAIL pulse_valid got %0d want 0", vrise_n - r0); end
    checks++; if (ferr_n - f0 !== 0) begin errors++; $display("FAIL pulse_ferr got %0d want 0", ferr_n - f0); end
  endtask

  task automatic test_frame_err;
    int c, r0, f0;
    r0 = vrise_n; f0 = ferr_n;
    send_frame(8'h3C, 1'b0, -1, c);
    wait_until(c + 199);
    checks++; if (ferr_n - f0 !== 1) begin errors++; $display("FAIL ferr_count got %0d want 1", ferr_n - f0); end
    checks++; if (ferr_cyc !== c + 155) begin errors++; $display("FAIL ferr_latency got %0d want %0d", ferr_cyc - c, 155); end
    checks++; if (vrise_n - r0 !== 0) begin errors++; $display("FAIL ferr_valid got %0d want 0", vrise_n - r0); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_held got %b want 1", busy); end
    demod_in = 1'b1;
    wait_until(c + 210);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int c1, c2, r0;
    dif.rx_ready = 1'b0;
    r0 = vrise_n;
    send_frame(8'h11, 1'b1, -1, c1);
    send_frame(8'h22, 1'b1, -1, c2);
    wait_until(c2 + 170);
    checks++; if (dif.rx_data !== 8'h11) begin errors++; $display("FAIL b2b_data got %h want 11", dif.rx_data); end
    checks++; if (dif.rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", dif.rx_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun got %b want 1", overrun); end
    checks++; if (vrise_n - r0 !== 1) begin errors++; $display("FAIL b2b_count got %0d want 1", vrise_n - r0); end
    dif.rx_ready = 1'b1;
    @(negedge clk);
    dif.rx_ready = 1'b0;
    checks++; if (dif.rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", dif.rx_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_sticky got %b want 1", overrun); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_err_clr got %b want 0", overrun); end
  endtask

  task automatic test_glitch;
    int c, r0;
    dif.rx_ready = 1'b1;
    r0 = vrise_n;
    // Offset 135 is the middle of bit 7's three vote samples
    send_frame(8'h80, 1'b1, 135, c);
    wait_until(c + 170);
    checks++; if (vrise_n - r0 !== 1) begin errors++; $display("FAIL glitch_count got %0d want 1", vrise_n - r0); end
    checks++; if (vrise_data !== 8'h80) begin errors++; $display("FAIL glitch_data got %h want 80", vrise_data); end
  endtask

  task automatic test_reset_midframe;
    int c, r0, f0;
    dif.rx_ready = 1'b0;
    send_frame(8'h33, 1'b1, -1, c);
    wait_until(c + 170);
    checks++; if (dif.rx_valid !== 1'b1) begin errors++; $display("FAIL prereset_valid got %b want 1", dif.rx_valid); end
    r0 = vrise_n; f0 = ferr_n;
    // 0xF8 keeps the line high from bit 3 on, so nothing restarts after reset
    @(negedge clk);
    c = cyc + 1;
    for (int i = 0; i < 160; i++) begin
      if (i > 0) @(negedge clk);
      demod_in = frame_bit(8'hF8, 1'b1, i);
      if (i == 71) rst_n = 1'b1;
      if (i == 70) begin
        rst_n = 1'b0;
        #1;
        checks++; if (dif.rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", dif.rx_valid); end
        checks++; if (dif.rx_data !== 8'h00) begin errors++; $display("FAIL midrst_data got %h want 00", dif.rx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst_ferr got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midrst_overrun got %b want 0", overrun); end
      end
    end
    wait_until(c + 200);
    checks++; if (vrise_n - r0 !== 0) begin errors++; $display("FAIL midrst_no_valid got %0d want 0", vrise_n - r0); end
    checks++; if (ferr_n - f0 !== 0) begin errors++; $display("FAIL midrst_no_ferr got %0d want 0", ferr_n - f0); end
    dif.rx_ready = 1'b1;
    r0 = vrise_n;
    send_frame(8'h5A, 1'b1, -1, c);
    wait_until(c + 170);
    checks++; if (vrise_n - r0 !== 1) begin errors++; $display("FAIL postrst_count got %0d want 1", vrise_n - r0); end
    checks++; if (vrise_data !== 8'h5A) begin errors++; $display("FAIL postrst_data got %h want 5a", vrise_data); end
    checks++; if (vrise_cyc !== c + 155) begin errors++; $display("FAIL postrst_latency got %0d want %0d", vrise_cyc - c, 155); end
  endtask

  initial begin
    dif.rx_ready = 1'b1;
    test_reset;
    test_basic;
    test_short_pulse;
    test_frame_err;
    test_back_to_back;
    test_glitch;
    test_reset_midframe;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
